// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: FSM state type and default geometry/timing constants for the SRAM access controller
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PRE, ACC, REC} state_t;
  localparam int ROWS_DEF = 64;
  localparam int DATA_W_DEF = 16;
  localparam int MUX_DEF = 4;
  localparam int PRECH_CYC_DEF = 1;
  localparam int WL_CYC_DEF = 2;
endpackage

// File: rtl/sram_col_mux.sv
// sram_col_mux: combinational column mux; gathers sa_out bit b*MUX+col_sel into rdata[b], scatters wdata into wd_en/wd_data
module sram_col_mux #(
  parameter int DATA_W = 16,
  parameter int MUX = 4
) (
  input  logic [$clog2(MUX)-1:0] col_sel,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W*MUX-1:0]  sa_out,
  output logic [DATA_W-1:0]      rdata,
  output logic [DATA_W*MUX-1:0]  wd_en,
  output logic [DATA_W*MUX-1:0]  wd_data
);
  localparam int CSW = $clog2(MUX);
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [MUX-1:0] grp;
    assign grp = sa_out[b*MUX +: MUX];
    assign rdata[b] = grp[col_sel];
    for (genvar c = 0; c < MUX; c++) begin : g_col
      assign wd_en[b*MUX+c] = col_sel == CSW'(c);
      assign wd_data[b*MUX+c] = (col_sel == CSW'(c)) & wdata[b];
    end
  end
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: SRAM precharge/wordline/sense/write sequencer (req_* in, rvalid/rdata out, wl/pre/write_en/sense_en/wd_* to array, sa_out from array); SRAM_ACCESS_CTRL_RDATA_REG_EN adds a read output register
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MUX = MUX_DEF,
  parameter int PRECH_CYC = PRECH_CYC_DEF,
  parameter int WL_CYC = WL_CYC_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [$clog2(ROWS)+$clog2(MUX)-1:0] req_addr,
  input  logic [DATA_W-1:0]                   req_wdata,
  output logic                                rvalid,
  output logic [DATA_W-1:0]                   rdata,
  output logic [ROWS-1:0]                     wl,
  output logic                                pre,
  output logic                                write_en,
  output logic                                sense_en,
  output logic [DATA_W*MUX-1:0]               wd_en,
  output logic [DATA_W*MUX-1:0]               wd_data,
  input  logic [DATA_W*MUX-1:0]               sa_out
);
  localparam int CSW = $clog2(MUX);
  localparam int RW = $clog2(ROWS);
  localparam int AW = RW + CSW;
  localparam int CMAX = PRECH_CYC > WL_CYC ? PRECH_CYC : WL_CYC;
  localparam int CW = $clog2(CMAX + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d, acc, last, accept, rd_cap, in_range;
  logic [AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, gath;
  logic [DATA_W*MUX-1:0] mask, scat;
  sram_col_mux #(.DATA_W(DATA_W), .MUX(MUX)) u_mux (
    .col_sel(addr_q[CSW-1:0]),
    .wdata(wdata_q),
    .sa_out(sa_out),
    .rdata(gath),
    .wd_en(mask),
    .wd_data(scat)
  );
  always_comb begin
    acc = state_q == ACC;
    last = cnt_q == CW'((state_q == PRE ? PRECH_CYC : WL_CYC) - 1);
    accept = state_q == IDLE && req_valid;
    state_d = accept ? PRE : (state_q == PRE && last) ? ACC : (acc && last) ? REC : state_q == REC ? IDLE : state_q;
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    we_d = accept ? req_we : we_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    in_range = {1'b0, addr_q[AW-1:CSW]} < (RW+1)'(ROWS);
    rd_cap = acc && !we_q && last;
    rdata_d = rd_cap ? (in_range ? gath : '0) : rdata_q;
  end
  assign req_ready = state_q == IDLE;
  assign pre = !acc;
  assign write_en = acc && we_q;
  assign sense_en = rd_cap;
  assign wd_en = write_en ? mask : '0;
  assign wd_data = write_en ? scat : '0;
  for (genvar r = 0; r < ROWS; r++) begin : g_wl
    assign wl[r] = acc && addr_q[AW-1:CSW] == RW'(r);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef SRAM_ACCESS_CTRL_RDATA_REG_EN
  logic rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_o_q, rdata_o_d;
  always_comb begin
    rvalid_d = state_q == REC && !we_q;
    rdata_o_d = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_o_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_o_q <= rdata_o_d;
    end
  end
  assign rvalid = rvalid_q;
  assign rdata = rdata_o_q;
`else
  assign rvalid = state_q == REC && !we_q;
  assign rdata = rdata_q;
`endif
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: random + directed bench with a schedule-level reference model for sram_access_ctrl (ROWS=64 and ROWS=48)
module tb_sram_access_ctrl;
`ifdef SRAM_ACCESS_CTRL_RDATA_REG_EN
  localparam int RLAT = 1;
`else
  localparam int RLAT = 0;
`endif
  localparam int P = 1, W = 2, L = P + W + 1;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [7:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic [63:0] sa_out = 0;
  logic ready, pre, we_o, se, rv, ready48, pre48, we48, se48, rv48;
  logic [15:0] rd, rd48;
  logic [63:0] wl, wden, wdd, wden48, wdd48;
  logic [47:0] wl48;
  int n_tests = 0, n_fail = 0;
  bit hold_sa = 0, armed = 0;
  always #5 clk = ~clk;
  sram_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rvalid(rv), .rdata(rd), .wl(wl), .pre(pre),
    .write_en(we_o), .sense_en(se), .wd_en(wden), .wd_data(wdd), .sa_out(sa_out)
  );
  sram_access_ctrl #(.ROWS(48)) dut48 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready48), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rvalid(rv48), .rdata(rd48), .wl(wl48), .pre(pre48),
    .write_en(we48), .sense_en(se48), .wd_en(wden48), .wd_data(wdd48), .sa_out(sa_out)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] gath(input logic [63:0] sa, input logic [7:0] a, input int rows);
    logic [15:0] g = '0;
    if (int'(a[7:2]) >= rows) return '0;
    for (int b = 0; b < 16; b++) g[b] = sa[b*4 + int'(a[1:0])];
    return g;
  endfunction
  function automatic logic [63:0] spread(input logic [15:0] d, input logic [1:0] c);
    logic [63:0] s = '0;
    for (int b = 0; b < 16; b++) s[b*4 + int'(c)] = d[b];
    return s;
  endfunction
  int t;
  logic mwe, erv;
  logic [7:0] maddr;
  logic [15:0] mwd, erd, erd48, lag, lag48;
  always @(posedge clk) begin
    if (rst) begin
      t <= 0; mwe <= 0; maddr <= 0; mwd <= 0; erv <= 0;
      erd <= 0; erd48 <= 0; lag <= 0; lag48 <= 0;
    end else begin
      erv <= t == L && !mwe;
      lag <= erd;
      lag48 <= erd48;
      if (t == P + W && !mwe) begin
        erd <= gath(sa_out, maddr, 64);
        erd48 <= gath(sa_out, maddr, 48);
      end
      if (t == 0 && req_valid) begin
        t <= 1; mwe <= req_we; maddr <= req_addr; mwd <= req_wdata;
      end else if (t != 0) t <= (t == L) ? 0 : t + 1;
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      logic acc;
      logic [63:0] ewl, ewl48;
      acc = t > P && t <= P + W;
      ewl = acc ? 64'b1 << maddr[7:2] : 64'b0;
      ewl48 = (acc && maddr[7:2] < 6'd48) ? 64'b1 << maddr[7:2] : 64'b0;
      chk("req_ready", 64'(ready), 64'(t == 0));
      chk("pre", 64'(pre), 64'(!acc));
      chk("wl", wl, ewl);
      chk("wl48", 64'(wl48), ewl48);
      chk("write_en", 64'(we_o), 64'(acc && mwe));
      chk("sense_en", 64'(se), 64'(acc && !mwe && t == P + W));
      chk("wd_en", wden, (acc && mwe) ? spread(16'hFFFF, maddr[1:0]) : 64'b0);
      chk("wd_data", wdd, (acc && mwe) ? spread(mwd, maddr[1:0]) : 64'b0);
      chk("rvalid", 64'(rv), 64'(RLAT ? erv : (t == L && !mwe)));
      chk("rdata", 64'(rd), 64'(RLAT ? lag : erd));
      chk("rvalid48", 64'(rv48), 64'(RLAT ? erv : (t == L && !mwe)));
      chk("rdata48", 64'(rd48), 64'(RLAT ? lag48 : erd48));
      chk("pre_wl_overlap", 64'(pre & (|wl)), 64'd0);
    end
  end
  initial forever begin
    @(negedge clk);
    if (!hold_sa) sa_out = {$urandom, $urandom};
  end
  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    chk("ready_timeout", 64'(ready), 64'd1);
  endtask
  task automatic access(input logic we, input logic [7:0] a, input logic [15:0] d, input logic [63:0] sa,
                        input logic [63:0] ewl, input logic [63:0] ewden, input logic [63:0] ewdd,
                        input int enwl, input int enwl48, input logic [15:0] erdl, input logic [15:0] erdl48);
    int nwl = 0, nwl48 = 0, nse = 0, rvk = 0;
    wait_ready();
    hold_sa = 1; sa_out = sa;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (wl != 0) begin
        nwl++;
        chk("dir_wl_onehot", wl, ewl);
        chk("dir_pre_in_acc", 64'(pre), 64'd0);
        if (we) begin
          chk("dir_wd_en", wden, ewden);
          chk("dir_wd_data", wdd, ewdd);
        end
      end
      if (wl48 != 0) nwl48++;
      if (se) nse++;
      if (rv && rvk == 0) rvk = k;
    end
    chk("dir_wl_cycles", 64'(nwl), 64'(enwl));
    chk("dir_wl48_cycles", 64'(nwl48), 64'(enwl48));
    if (!we) begin
      chk("dir_rvalid_latency", 64'(rvk), 64'(4 + RLAT));
      chk("dir_sense_cycles", 64'(nse), 64'd1);
      chk("dir_rdata", 64'(rd), 64'(erdl));
      chk("dir_rdata48", 64'(rd48), 64'(erdl48));
    end else chk("dir_sense_on_write", 64'(nse), 64'd0);
    hold_sa = 0;
  endtask
  initial begin
    int last, gaps;
    repeat (3) @(posedge clk);
    @(negedge clk);
    armed = 1;
    rst = 0;
    @(negedge clk);
    chk("rst_pre", 64'(pre), 64'd1);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_wl", wl, 64'd0);
    chk("rst_wd_en", wden, 64'd0);
    chk("rst_rvalid", 64'(rv), 64'd0);
    chk("rst_rdata", 64'(rd), 64'd0);
    access(1, 8'h16, 16'hA5A5, 64'd0, 64'h20, 64'h4444_4444_4444_4444, 64'h4040_0404_4040_0404, 2, 2, 0, 0);
    access(0, 8'h16, 16'h0, 64'h4040_0404_4040_0404, 64'h20, 0, 0, 2, 2, 16'hA5A5, 16'hA5A5);
    access(0, 8'hFD, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 0, 2, 0, 16'hFFFF, 16'h0000);
    access(0, 8'h00, 16'h0, 64'h0000_0000_0000_0001, 64'h1, 0, 0, 2, 2, 16'h0001, 16'h0001);
    access(0, 8'hCB, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0004_0000_0000_0000, 0, 0, 2, 0, 16'hFFFF, 16'h0000);
    wait_ready();
    req_valid = 1; req_we = 0; req_addr = 8'h37;
    last = -1; gaps = 0;
    for (int i = 0; i < 30; i++) begin
      if (ready) begin
        if (last >= 0) begin
          chk("b2b_gap", 64'(i - last), 64'(1 + P + W + 1));
          gaps++;
        end
        last = i;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("b2b_count", 64'(gaps), 64'd5);
    wait_ready();
    req_valid = 1; req_we = 1; req_addr = 8'h16; req_wdata = 16'h1234;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("mid_acc_write_en", 64'(we_o), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_wl", wl, 64'd0);
    chk("mid_rst_write_en", 64'(we_o), 64'd0);
    chk("mid_rst_pre", 64'(pre), 64'd1);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    chk("mid_rst_rdata", 64'(rd), 64'd0);
    chk("mid_rst_rvalid", 64'(rv), 64'd0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 127) == 0;
      req_valid = $urandom_range(0, 1) == 1;
      req_we = $urandom_range(0, 1) == 1;
      req_addr = 8'($urandom);
      req_wdata = 16'($urandom);
    end
    @(negedge clk);
    rst = 0; req_valid = 0;
    repeat (8) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
